dbus_mmio: RTL and testbench
============================

# dbus_mmio

Data-bus splitter and memory-mapped I/O block between the RISC core's data port and the data RAM on the DE1-SoC top level. It decodes every data access. It forwards RAM-region accesses to the RAM, including byte-lane strobes. It serves I/O-region accesses from local registers: LEDs, seven-segment displays, synchronized switches and keys, sticky key-press flags, and an optional cycle timer. It returns read data to the core with the same one-cycle latency and `valid` semantics as the RAM.

## Interface
Parameters:
- `IO_NIBBLE`, default 4'h8: value of `d_address[31:28]` that selects the I/O region; any other value selects RAM.

Ports:
- `clk`  in  1  system clock (clock_50 domain)
- `reset`  in  1  synchronous, active-high reset
- `d_address`  in  32  core data byte address
- `d_data_write`  in  32  core write data
- `d_write_enable`  in  1  core write request
- `d_data_wstrb`  in  4  byte-lane enables for the write
- `d_data_read`  out  32  read data to core
- `d_data_valid`  out  1  read data valid to core
- `ram_addr`  out  32  address to RAM (equals `d_address`)
- `ram_wdata`  out  32  write data to RAM
- `ram_we`  out  1  RAM write enable
- `ram_wstrb`  out  4  RAM byte-lane enables
- `ram_rdata`  in  32  RAM read data
- `ram_rdata_valid`  in  1  RAM read data valid
- `sw`  in  10  board switches (asynchronous)
- `key`  in  4  board keys, active-low (asynchronous)
- `ledr`  out  10  LEDs
- `hex0`..`hex5`  out  7 each  segments, active-low

## Operation
**Decode.** `io_hit = (d_address[31:28] == IO_NIBBLE)`. Register offset is `d_address[5:2]`.

**RAM path.**
- `ram_addr = d_address`; `ram_wdata = d_data_write`; `ram_wstrb = d_data_wstrb`.
- `ram_we = d_write_enable & ~io_hit`. Combinational, so the RAM sees the request in the same cycle.

**I/O writes.** Occur when `d_write_enable & io_hit`. RW registers update only the byte lanes set in `d_data_wstrb`.

**Reads.** Every cycle with `~d_write_enable` is a read. No read has side effects.

**Register map** (byte offset from I/O base):
- 0x00 LEDR, RW, bits [9:0]. Drives `ledr` directly. Resets to 0.
- 0x04 HEX_LO, RW. hex0 in [6:0], hex1 in [14:8], hex2 in [22:16], hex3 in [30:24]. A stored 1 means the segment is lit; the output pin is the inverted bit. Resets to 0, so all hex outputs are 7'h7F.
- 0x08 HEX_HI, RW. hex4 in [6:0], hex5 in [14:8]. Same encoding and reset as HEX_LO.
- 0x0C SW, RO. Two-flop synchronized `sw`.
- 0x10 KEY, RO. Synchronized `~key`, so 1 = pressed.
- 0x14 KEY_EDGE, write-1-to-clear, bits [3:0]. A bit sets on the synchronized press edge (0→1 of pressed). If set and clear occur in the same cycle, set wins.
- 0x18 TIMER, 0x1C TIMER_CMP, 0x20 TIMER_STAT: present only with the macro; see Configuration.
- Unmapped offsets read 0; writes to them are ignored. Unused bits in mapped registers read 0.

## Timing
- **I/O read latency.** A read at cycle N registers `io_sel_q = io_hit` and the register value. At N+1: `d_data_read = io_rdata_q` and `d_data_valid = 1`.
- **RAM read path.** At N+1 with `io_sel_q = 0`: `d_data_read = ram_rdata` and `d_data_valid = ram_rdata_valid`.
- **I/O write latency.** An I/O write at N is visible on the pins and in readback from N+1.
- **Write cycles.** A write cycle at N gives `d_data_valid = 0` at N+1 for the I/O path; the RAM path passes through the RAM's own valid.
- **Input latency.** Inputs take 2 cycles through the synchronizer. The edge flag sets 3 cycles after a key falls.
- **Reset.** All registers clear: LEDR 0, HEX registers 0, KEY_EDGE 0, synchronizer flops 0, `io_sel_q` 0, `io_rdata_q` 0. Outputs during reset: `d_data_valid` 0, `ledr` 0, hex 7'h7F. Reset asserted mid-access discards the pending I/O read.

## Configuration
Macro: `DBUS_MMIO_TIMER_EN`.

Defined:
- TIMER is a 32-bit free-running counter, +1 per cycle, wrapping 0xFFFFFFFF→0. A write loads it with strobes applied; if a write and the increment occur in the same cycle, the write wins.
- TIMER_CMP resets to 0xFFFFFFFF.
- TIMER_STAT bit 0 is a sticky match flag. It sets when TIMER == TIMER_CMP and is write-1-to-clear; set wins over clear in the same cycle.
- TIMER resets to 0.

Undefined:
- No timer logic. Offsets 0x18, 0x1C and 0x20 read 0 and ignore writes.

## Structure
- Package `dbus_pkg`: `IO_NIBBLE` default, offset localparams (`OFF_LEDR` … `OFF_TIMER_STAT`), and a register-offset enum.
- Sub-module `sync_edge`, parameterized width `W`: two-flop synchronizer plus rising-edge pulse output. Instantiated once for `sw` (W=10) and once for `~key` (W=4).

## Test plan
- **Reset.** Assert `reset` → `ledr` = 0, `hex0`..`hex5` = 7'h7F, `d_data_valid` = 0.
- **I/O byte-lane write.** Write 0x8000_0004 with data 0x0000_3F06 and wstrb 4'b0011 → `hex0` = 7'h79, `hex1` = 7'h40. Then write wstrb 4'b0001 with data 0 → `hex0` = 7'h7F, `hex1` unchanged.
- **RAM routing.** Write 0x0000_0010 with data 0xDEAD_BEEF and wstrb 4'hF → `ram_we` = 1 and LEDR unchanged. Read the same address → `d_data_read` = 0xDEAD_BEEF at N+1.
- **I/O read latency.** Write LEDR = 0x2A5, then read 0x8000_0000 at cycle N → `d_data_valid` = 1 and `d_data_read` = 0x2A5 at N+1. `ram_we` stays 0 throughout.
- **Key edge flag.** Drive `key[2]` low → KEY bit 2 = 1 after 2 cycles and KEY_EDGE = 4'b0100 after 3 cycles. A press pulse coincident with a W1C write of 4'b0100 leaves the bit set.
- **Timer (with `DBUS_MMIO_TIMER_EN`).** Write TIMER = 0xFFFF_FFFE and TIMER_CMP = 0x0000_0001 → TIMER wraps through 0, and TIMER_STAT bit 0 = 1 two cycles after the wrap. Without the macro, a read of 0x8000_0018 returns 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared definitions for the dbus_mmio data-bus splitter: I/O region select,
// register byte offsets, register index enum and a byte-lane merge helper.
package dbus_pkg;

  localparam logic [3:0] IO_NIBBLE_DEFAULT = 4'h8;

  localparam logic [7:0] OFF_LEDR       = 8'h00;
  localparam logic [7:0] OFF_HEX_LO     = 8'h04;
  localparam logic [7:0] OFF_HEX_HI     = 8'h08;
  localparam logic [7:0] OFF_SW         = 8'h0C;
  localparam logic [7:0] OFF_KEY        = 8'h10;
  localparam logic [7:0] OFF_KEY_EDGE   = 8'h14;
  localparam logic [7:0] OFF_TIMER      = 8'h18;
  localparam logic [7:0] OFF_TIMER_CMP  = 8'h1C;
  localparam logic [7:0] OFF_TIMER_STAT = 8'h20;

  // Word index of each register, i.e. d_address[5:2]
  typedef enum logic [3:0] {
    REG_LEDR       = OFF_LEDR[5:2],
    REG_HEX_LO     = OFF_HEX_LO[5:2],
    REG_HEX_HI     = OFF_HEX_HI[5:2],
    REG_SW         = OFF_SW[5:2],
    REG_KEY        = OFF_KEY[5:2],
    REG_KEY_EDGE   = OFF_KEY_EDGE[5:2],
    REG_TIMER      = OFF_TIMER[5:2],
    REG_TIMER_CMP  = OFF_TIMER_CMP[5:2],
    REG_TIMER_STAT = OFF_TIMER_STAT[5:2]
  } reg_off_e;

  // Replace only the byte lanes of old_val whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_mmio_sync_edge.sv
// Two-flop synchronizer for asynchronous board inputs, plus a one-cycle
// pulse on each synchronized 0->1 transition.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the pre-edge value of the one before; blocking would collapse the chain into one flop.
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/dbus_mmio.sv
// dbus_mmio: splits the core data port between the data RAM and a small bank
// of memory-mapped board I/O registers (LEDs, seven-segment, switches, keys).
// Define DBUS_MMIO_TIMER_EN to add the free-running cycle timer registers.
module dbus_mmio
  import dbus_pkg::*;
#(
  parameter logic [3:0] IO_NIBBLE = IO_NIBBLE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic        d_write_enable,
  input  logic [3:0]  d_data_wstrb,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  input  logic        ram_rdata_valid,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  ledr,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  logic        io_hit;
  logic        io_we;
  reg_off_e    off;

  logic [9:0]       ledr_q;
  logic [5:0][6:0]  seg_q;       // stored 1 = segment lit
  logic [3:0]       key_edge_q;
  logic [9:0]       sw_s;
  logic [9:0]       sw_rise_unused;
  logic [3:0]       key_s;       // 1 = pressed
  logic [3:0]       key_rise;
  logic [3:0]       key_edge_clr;

  logic        io_sel_q;
  logic        io_valid_q;
  logic [31:0] io_rdata;
  logic [31:0] io_rdata_q;

  assign io_hit = (d_address[31:28] == IO_NIBBLE);
  assign io_we  = d_write_enable & io_hit;
  assign off    = reg_off_e'(d_address[5:2]);

  // RAM sees every access combinationally; only its write enable is gated
  assign ram_addr  = d_address;
  assign ram_wdata = d_data_write;
  assign ram_wstrb = d_data_wstrb;
  assign ram_we    = d_write_enable & ~io_hit;

  sync_edge #(.W(10)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sw),
    .dout  (sw_s),
    .rise  (sw_rise_unused)
  );

  sync_edge #(.W(4)) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .din   (~key),
    .dout  (key_s),
    .rise  (key_rise)
  );

  assign key_edge_clr = (io_we && off == REG_KEY_EDGE && d_data_wstrb[0])
                        ? d_data_write[3:0] : 4'h0;

  // Board-facing RW registers and the sticky key-press flags
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_q     <= '0;
      seg_q      <= '0;
      key_edge_q <= '0;
    end else begin
      if (io_we && off == REG_LEDR) begin
        if (d_data_wstrb[0]) ledr_q[7:0] <= d_data_write[7:0];
        if (d_data_wstrb[1]) ledr_q[9:8] <= d_data_write[9:8];
      end
      if (io_we && off == REG_HEX_LO) begin
        for (int b = 0; b < 4; b++) begin
          if (d_data_wstrb[b]) seg_q[b] <= d_data_write[8*b +: 7];
        end
      end
      if (io_we && off == REG_HEX_HI) begin
        for (int b = 0; b < 2; b++) begin
          if (d_data_wstrb[b]) seg_q[4+b] <= d_data_write[8*b +: 7];
        end
      end
      // A press pulse in the same cycle as a clear keeps the flag set
      key_edge_q <= (key_edge_q & ~key_edge_clr) | key_rise;
    end
  end

`ifdef DBUS_MMIO_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_cmp_q;
  logic        timer_stat_q;
  logic        timer_stat_clr;

  assign timer_stat_clr = io_we && off == REG_TIMER_STAT &&
                          d_data_wstrb[0] && d_data_write[0];

  // Free-running timer, compare register and sticky match flag
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q      <= '0;
      timer_cmp_q  <= '1;
      timer_stat_q <= 1'b0;
    end else begin
      if (io_we && off == REG_TIMER)
        timer_q <= apply_wstrb(timer_q, d_data_write, d_data_wstrb);
      else
        timer_q <= timer_q + 32'd1;
      if (io_we && off == REG_TIMER_CMP)
        timer_cmp_q <= apply_wstrb(timer_cmp_q, d_data_write, d_data_wstrb);
      timer_stat_q <= (timer_stat_q & ~timer_stat_clr) | (timer_q == timer_cmp_q);
    end
  end
`endif

  // Register read mux; unmapped offsets and unused bits read 0
  always_comb begin
    // NOTE: default assigned first so every path drives io_rdata and no latch is inferred.
    io_rdata = '0;
    case (off)
      REG_LEDR:       io_rdata = {22'd0, ledr_q};
      REG_HEX_LO:     io_rdata = {1'b0, seg_q[3], 1'b0, seg_q[2], 1'b0, seg_q[1], 1'b0, seg_q[0]};
      REG_HEX_HI:     io_rdata = {16'd0, 1'b0, seg_q[5], 1'b0, seg_q[4]};
      REG_SW:         io_rdata = {22'd0, sw_s};
      REG_KEY:        io_rdata = {28'd0, key_s};
      REG_KEY_EDGE:   io_rdata = {28'd0, key_edge_q};
`ifdef DBUS_MMIO_TIMER_EN
      REG_TIMER:      io_rdata = timer_q;
      REG_TIMER_CMP:  io_rdata = timer_cmp_q;
      REG_TIMER_STAT: io_rdata = {31'd0, timer_stat_q};
`endif
      default:        io_rdata = '0;
    endcase
  end

  // One-cycle read return stage matching the RAM's latency
  always_ff @(posedge clk) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_valid_q <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= io_hit;
      io_valid_q <= io_hit & ~d_write_enable;
      if (io_hit && !d_write_enable) io_rdata_q <= io_rdata;
    end
  end

  assign d_data_read  = io_sel_q ? io_rdata_q : ram_rdata;
  assign d_data_valid = ~reset & (io_sel_q ? io_valid_q : ram_rdata_valid);

  assign ledr = ledr_q;
  assign hex0 = ~seg_q[0];
  assign hex1 = ~seg_q[1];
  assign hex2 = ~seg_q[2];
  assign hex3 = ~seg_q[3];
  assign hex4 = ~seg_q[4];
  assign hex5 = ~seg_q[5];

endmodule

// File: tb/tb_dbus_mmio.sv
// Scoreboard bench for dbus_mmio: directed scenarios then random traffic,
// checked against a word-level model of the register map and a RAM image.
module tb_dbus_mmio;

  logic        clk;
  logic        reset;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic        d_write_enable;
  logic [3:0]  d_data_wstrb;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;
  logic        ram_rdata_valid = 1'b0;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  dbus_mmio dut (
    .clk             (clk),
    .reset           (reset),
    .d_address       (d_address),
    .d_data_write    (d_data_write),
    .d_write_enable  (d_write_enable),
    .d_data_wstrb    (d_data_wstrb),
    .d_data_read     (d_data_read),
    .d_data_valid    (d_data_valid),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_wstrb       (ram_wstrb),
    .ram_rdata       (ram_rdata),
    .ram_rdata_valid (ram_rdata_valid),
    .sw              (sw),
    .key             (key),
    .ledr            (ledr),
    .hex0            (hex0),
    .hex1            (hex1),
    .hex2            (hex2),
    .hex3            (hex3),
    .hex4            (hex4),
    .hex5            (hex5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM stand-in: one-cycle read latency, byte-lane writes
  logic [31:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata       <= ram_mem[ram_addr[5:2]];
    ram_rdata_valid <= !reset && !ram_we;
  end

  // Reference model state
  logic [31:0] regs_m  [16];
  logic [31:0] wmask_m [16];
  logic [31:0] ram_ref [16];
  logic [9:0]  sw_hist [4];   // [k] = value driven k cycles ago
  logic [3:0]  key_hist [4];
  logic [3:0]  edge_m;
  logic [31:0] timer_m, cmp_m;
  logic        stat_m;
  logic [31:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    edge_m  = '0;
    timer_m = '0;
    cmp_m   = 32'hFFFF_FFFF;
    stat_m  = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] off);
    case (off)
      4'd0, 4'd1, 4'd2: return regs_m[off];
      4'd3: return {22'd0, sw_hist[2]};
      4'd4: return {28'd0, ~key_hist[2]};
      4'd5: return {28'd0, edge_m};
`ifdef DBUS_MMIO_TIMER_EN
      4'd6: return timer_m;
      4'd7: return cmp_m;
      4'd8: return {31'd0, stat_m};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [51:0] model_pins();
    return {regs_m[0][9:0], ~regs_m[2][14:8], ~regs_m[2][6:0],
            ~regs_m[1][30:24], ~regs_m[1][22:16], ~regs_m[1][14:8], ~regs_m[1][6:0]};
  endfunction

  // Monitor: every valid read return is matched against the oldest expectation
  always @(negedge clk) begin
    if (d_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rdata_unexpected: got valid data %h, expected no response", d_data_read);
      end else begin
        check("rdata", d_data_read, exp_q.pop_front());
      end
    end
  end

  // One bus cycle: drive at posedge+1, check pins at negedge, advance model
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic rst, input logic expect_rsp);
    logic        io;
    logic [3:0]  off;
    logic [31:0] lanes;
    logic [3:0]  clr;
    logic        stat_clr;
    d_write_enable = we;
    d_address      = addr;
    d_data_write   = data;
    d_data_wstrb   = strb;
    reset          = rst;
    for (int k = 3; k > 0; k--) begin
      sw_hist[k]  = sw_hist[k-1];
      key_hist[k] = key_hist[k-1];
    end
    sw_hist[0]  = sw;
    key_hist[0] = key;
    io    = (addr[31:28] == 4'h8);
    off   = addr[5:2];
    lanes = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    @(negedge clk);
    check("ram_we", ram_we, we & ~io);
    check("pins", {ledr, hex5, hex4, hex3, hex2, hex1, hex0}, model_pins());
    if (!we && expect_rsp) exp_q.push_back(io ? model_read(off) : ram_ref[addr[5:2]]);
    if (rst) begin
      model_reset();
    end else begin
      clr      = (we && io && off == 4'd5 && strb[0]) ? data[3:0] : 4'h0;
      edge_m   = (edge_m & ~clr) | (~key_hist[2] & key_hist[3]);
      stat_clr = we && io && off == 4'd8 && strb[0] && data[0];
      stat_m   = (stat_m & ~stat_clr) | (timer_m == cmp_m);
      if (we && io && off == 4'd7) cmp_m = (cmp_m & ~lanes) | (data & lanes);
      if (we && io && off == 4'd6) timer_m = (timer_m & ~lanes) | (data & lanes);
      else                         timer_m = timer_m + 32'd1;
      if (we && io)  regs_m[off] = (regs_m[off] & ~(wmask_m[off] & lanes)) | (data & wmask_m[off] & lanes);
      if (we && !io) ram_ref[addr[5:2]] = (ram_ref[addr[5:2]] & ~lanes) | (data & lanes);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] r, r2, a, dat;
    logic [3:0]  nib;
    int          op;

    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = '0;
      ram_ref[i] = '0;
      wmask_m[i] = '0;
    end
    wmask_m[0] = 32'h0000_03FF;
    wmask_m[1] = 32'h7F7F_7F7F;
    wmask_m[2] = 32'h0000_7F7F;
    sw  = '0;
    key = 4'hF;
    for (int k = 0; k < 4; k++) begin
      sw_hist[k]  = '0;
      key_hist[k] = 4'hF;
    end
    model_reset();
    reset = 1'b1;
    d_write_enable = 1'b0;
    d_address = '0;
    d_data_write = '0;
    d_data_wstrb = '0;

    // Reset state
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b1, 1'b0);
    check("reset_valid", d_data_valid, 1'b0);
    check("reset_ledr", ledr, 10'd0);
    check("reset_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});

    // Byte-lane write to HEX_LO
    xact(1'b1, 32'h8000_0004, 32'h0000_3F06, 4'b0011, 1'b0, 1'b0);
    check("hex0_lane", hex0, 7'h79);
    check("hex1_lane", hex1, 7'h40);
    check("hex2_untouched", hex2, 7'h7F);
    xact(1'b1, 32'h8000_0004, 32'h0000_0000, 4'b0001, 1'b0, 1'b0);
    check("hex0_cleared", hex0, 7'h7F);
    check("hex1_kept", hex1, 7'h40);

    // RAM routing
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    xact(1'b0, 32'h0000_0010, 32'd0, 4'h0, 1'b0, 1'b1);
    check("ram_rd_valid", d_data_valid, 1'b1);
    check("ram_rd_data", d_data_read, 32'hDEAD_BEEF);

    // I/O read latency
    xact(1'b1, 32'h8000_0000, 32'h0000_02A5, 4'hF, 1'b0, 1'b0);
    check("ledr_pins", ledr, 10'h2A5);
    xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, 1'b1);
    check("io_rd_valid", d_data_valid, 1'b1);
    check("io_rd_data", d_data_read, 32'h0000_02A5);

    // Key synchronizer and press-edge flag
    key = 4'b1011;
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, 1'b0, 1'b1);
    check("key_after2", d_data_read, 32'h4);
    xact(1'b0, 32'h8000_0014, 32'd0, 4'h0, 1'b0, 1'b1);
    check("key_edge_after3", d_data_read, 32'h4);
    key = 4'b1001;
    for (int i = 0; i < 4; i++) xact(1'b0, 32'h8000_0014, 32'd0, 4'h0, 1'b0, 1'b1);
    key = 4'hF;
    idle(4);
    xact(1'b1, 32'h8000_0014, 32'h0000_000F, 4'h1, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0014, 32'd0, 4'h0, 1'b0, 1'b1);
    key = 4'b1011;
    idle(2);
    xact(1'b1, 32'h8000_0014, 32'h0000_0004, 4'h1, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0014, 32'd0, 4'h0, 1'b0, 1'b1);
    check("edge_set_wins", d_data_read, 32'h4);
    key = 4'hF;
    idle(4);

`ifdef DBUS_MMIO_TIMER_EN
    xact(1'b1, 32'h8000_0018, 32'hFFFF_FFFE, 4'hF, 1'b0, 1'b0);
    xact(1'b1, 32'h8000_001C, 32'h0000_0001, 4'hF, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0018, 32'd0, 4'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h8000_0018, 32'd0, 4'h0, 1'b0, 1'b1);
    check("timer_wrap", d_data_read, 32'h0);
    xact(1'b0, 32'h8000_0018, 32'd0, 4'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h8000_0020, 32'd0, 4'h0, 1'b0, 1'b1);
    check("timer_stat_set", d_data_read, 32'h1);
    xact(1'b1, 32'h8000_0020, 32'h0000_0001, 4'h1, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0020, 32'd0, 4'h0, 1'b0, 1'b1);
    check("timer_stat_clr", d_data_read, 32'h0);
`else
    xact(1'b1, 32'h8000_0018, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0018, 32'd0, 4'h0, 1'b0, 1'b1);
    check("timer_absent_valid", d_data_valid, 1'b1);
    check("timer_absent_data", d_data_read, 32'h0);
`endif

    // Reset during a pending I/O read drops the response
    xact(1'b1, 32'h8000_0000, 32'h0000_0155, 4'hF, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, 1'b0);
    xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b1, 1'b0);
    check("midreset_valid", d_data_valid, 1'b0);
    xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r  = $urandom();
      r2 = $urandom();
      dat = $urandom();
      if (r[31:29] == 3'd0) sw  = r2[25:16];
      if (r[28:26] == 3'd0) key = r2[29:26];
      op = $urandom_range(0, 3);
      nib = r2[31:28];
      if (nib == 4'h8) nib = 4'h0;
      case (op)
        0: a = {4'h8, r[21:0], r2[3:0], 2'b00};
        1: a = {4'h8, r[21:0], r2[3:0], 2'b00};
        default: a = {nib, 22'd0, r2[3:0], 2'b00};
      endcase
      xact((op == 0 || op == 2), a, dat, r[25:22], 1'b0, 1'b1);
    end

    // Drain the last response with a write that returns nothing
    xact(1'b1, 32'h8000_003C, 32'd0, 4'h0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
